// File: rtl/exec_sequencer_if.sv
// Fetch/unit-facing bundle of the execute-stage sequencer.
// slave: the sequencer itself; master: fetch, execution units and stall source.
interface exec_sequencer_if;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic        instruction_ready;
    logic [31:0] current_instruction;
    logic        alu_imm_enable_n;
    logic        alu_reg_enable_n;
    logic        branch_enable_n;
    logic        stall;
    logic        register_write_n;
    logic        pc_advance;
    logic        trap;
    logic        trap_clear;

    modport slave (
        input  instruction_valid, instruction, stall, trap_clear,
        output instruction_ready, current_instruction,
               alu_imm_enable_n, alu_reg_enable_n, branch_enable_n,
               register_write_n, pc_advance, trap
    );

    modport master (
        output instruction_valid, instruction, stall, trap_clear,
        input  instruction_ready, current_instruction,
               alu_imm_enable_n, alu_reg_enable_n, branch_enable_n,
               register_write_n, pc_advance, trap
    );
endinterface

// File: rtl/exec_sequencer.sv
// Execute-stage control FSM: decodes the major opcode, enables exactly one
// execution unit, and times the register-file write and PC-advance strobes.
module exec_sequencer #(
    parameter int unsigned EXEC_CYCLES = 1   // legal range 1..15
) (
    input  logic clk,
    input  logic reset_n,
    exec_sequencer_if.slave seq_if
);
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK, S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        U_NONE, U_IMM, U_REG, U_BR
    } unit_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    unit_t       unit_q, unit_d, dec_unit;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic        wb_held_q, wb_held_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            unit_q    <= U_NONE;
            cnt_q     <= 4'd0;
            instr_q   <= 32'd0;
            wb_held_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            unit_q    <= unit_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            wb_held_q <= wb_held_d;
        end
    end

    always_comb begin
        unit_t dec;
        dec = U_NONE;
        unique case (instr_q[6:0])
            7'b0010011: dec = U_IMM;
            7'b0110011: dec = U_REG;
            7'b1100011: dec = U_BR;
            default:    dec = U_NONE;
        endcase
        dec_unit = dec;
    end

    always_comb begin
        state_d   = state_q;
        unit_d    = unit_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        wb_held_d = wb_held_q;
        case (state_q)
            S_IDLE: begin
                if (seq_if.instruction_valid) begin
                    instr_d = seq_if.instruction;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unit_d = dec_unit;
                if (dec_unit == U_NONE) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXECUTE;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_EXECUTE: begin
                if (!seq_if.stall) begin
                    if (cnt_q == 4'd0) begin
                        state_d   = S_WRITEBACK;
                        wb_held_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            S_WRITEBACK: begin
                // Strobes fire on WRITEBACK entry only; a stalled writeback
                // keeps them low so the retire is never reported twice.
                if (seq_if.stall) begin
                    wb_held_d = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                    unit_d    = U_NONE;
                    wb_held_d = 1'b0;
                end
            end
            S_TRAP: begin
                if (seq_if.trap_clear) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are pure decodes of registered state: no input-to-output path.
    logic unit_active, wb_strobe;
    assign unit_active = (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
    assign wb_strobe   = (state_q == S_WRITEBACK) && !wb_held_q;

    assign seq_if.instruction_ready   = (state_q == S_IDLE);
    assign seq_if.current_instruction = instr_q;
    assign seq_if.alu_imm_enable_n    = !(unit_active && unit_q == U_IMM);
    assign seq_if.alu_reg_enable_n    = !(unit_active && unit_q == U_REG);
    assign seq_if.branch_enable_n     = !(unit_active && unit_q == U_BR);
    assign seq_if.register_write_n    = !(wb_strobe && (unit_q == U_IMM || unit_q == U_REG)
                                          && instr_q[11:7] != 5'd0);
    assign seq_if.pc_advance          = wb_strobe;
    assign seq_if.trap                = (state_q == S_TRAP);
endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench: EXEC_CYCLES=1 instance for single-instruction scenarios,
// EXEC_CYCLES=4 instance for back-to-back throughput.
module tb_exec_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    exec_sequencer_if if1();
    exec_sequencer_if if4();

    exec_sequencer #(.EXEC_CYCLES(1)) dut1 (.clk(clk), .reset_n(reset_n), .seq_if(if1.slave));
    exec_sequencer #(.EXEC_CYCLES(4)) dut4 (.clk(clk), .reset_n(reset_n), .seq_if(if4.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // enables packed as {imm, reg, br}
    function automatic logic [2:0] en1();
        return {if1.alu_imm_enable_n, if1.alu_reg_enable_n, if1.branch_enable_n};
    endfunction

    initial begin
        int accepts, pulses, first_pc, last_pc, gap_bad, overlap, imm_low, lows;

        if1.instruction_valid = 1'b0; if1.instruction = 32'd0;
        if1.stall = 1'b0;             if1.trap_clear = 1'b0;
        if4.instruction_valid = 1'b0; if4.instruction = 32'd0;
        if4.stall = 1'b0;             if4.trap_clear = 1'b0;

        // reset values
        tick(); tick();
        check("rst_ready", 32'(if1.instruction_ready), 32'd1);
        check("rst_ci",    if1.current_instruction,   32'd0);
        check("rst_en",    32'(en1()),                32'd7);
        check("rst_wr",    32'(if1.register_write_n), 32'd1);
        check("rst_pc",    32'(if1.pc_advance),       32'd0);
        check("rst_trap",  32'(if1.trap),             32'd0);
        reset_n = 1'b1;
        tick();

        // 1: addi x5,x0,7
        if1.instruction_valid = 1'b1; if1.instruction = 32'h00700293;
        tick();
        if1.instruction_valid = 1'b0;
        check("t1_dec_ready", 32'(if1.instruction_ready), 32'd0);
        check("t1_dec_ci",    if1.current_instruction,   32'h00700293);
        check("t1_dec_en",    32'(en1()),                32'd7);
        tick();
        check("t1_ex_en",     32'(en1()),                32'b011);
        check("t1_ex_wr",     32'(if1.register_write_n), 32'd1);
        check("t1_ex_pc",     32'(if1.pc_advance),       32'd0);
        tick();
        check("t1_wb_en",     32'(en1()),                32'b011);
        check("t1_wb_wr",     32'(if1.register_write_n), 32'd0);
        check("t1_wb_pc",     32'(if1.pc_advance),       32'd1);
        tick();
        check("t1_idle_en",   32'(en1()),                32'd7);
        check("t1_idle_wr",   32'(if1.register_write_n), 32'd1);
        check("t1_idle_pc",   32'(if1.pc_advance),       32'd0);
        check("t1_idle_rdy",  32'(if1.instruction_ready), 32'd1);

        // 2: add x0,x1,x2 -- rd=0, no write
        if1.instruction_valid = 1'b1; if1.instruction = 32'h00208033;
        tick();
        if1.instruction_valid = 1'b0;
        tick();
        check("t2_ex_en",  32'(en1()),                32'b101);
        tick();
        check("t2_wb_en",  32'(en1()),                32'b101);
        check("t2_wb_pc",  32'(if1.pc_advance),       32'd1);
        check("t2_wb_wr",  32'(if1.register_write_n), 32'd1);
        tick();
        check("t2_idle_pc", 32'(if1.pc_advance),      32'd0);

        // 3: beq with 3 stall cycles in EXECUTE
        if1.instruction_valid = 1'b1; if1.instruction = 32'h00208463;
        tick();
        if1.instruction_valid = 1'b0;
        tick();
        check("t3_ex0_en", 32'(en1()), 32'b110);
        if1.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_en", 32'(en1()),                32'b110);
            check("t3_stall_pc", 32'(if1.pc_advance),       32'd0);
            check("t3_stall_wr", 32'(if1.register_write_n), 32'd1);
        end
        if1.stall = 1'b0;
        tick();
        check("t3_wb_en", 32'(en1()),                32'b110);
        check("t3_wb_pc", 32'(if1.pc_advance),       32'd1);
        check("t3_wb_wr", 32'(if1.register_write_n), 32'd1);
        tick();
        check("t3_idle_en", 32'(en1()),          32'd7);
        check("t3_idle_pc", 32'(if1.pc_advance), 32'd0);

        // 4: illegal opcode -> sticky trap
        if1.instruction_valid = 1'b1; if1.instruction = 32'h0000007F;
        tick();
        if1.instruction = 32'h00700293;
        check("t4_dec_trap", 32'(if1.trap), 32'd0);
        tick();
        check("t4_trap",     32'(if1.trap),              32'd1);
        check("t4_ready",    32'(if1.instruction_ready), 32'd0);
        check("t4_en",       32'(en1()),                 32'd7);
        tick();
        check("t4_sticky",   32'(if1.trap),              32'd1);
        check("t4_ci_hold",  if1.current_instruction,    32'h0000007F);
        if1.instruction_valid = 1'b0;
        if1.trap_clear = 1'b1;
        tick();
        if1.trap_clear = 1'b0;
        check("t4_clr_trap",  32'(if1.trap),              32'd0);
        check("t4_clr_ready", 32'(if1.instruction_ready), 32'd1);

        // 5: reset mid-EXECUTE
        if1.instruction_valid = 1'b1; if1.instruction = 32'h00700293;
        tick();
        if1.instruction_valid = 1'b0;
        tick();
        check("t5_ex_en", 32'(en1()), 32'b011);
        reset_n = 1'b0;
        #1;
        check("t5_rst_en",    32'(en1()),                 32'd7);
        check("t5_rst_wr",    32'(if1.register_write_n),  32'd1);
        check("t5_rst_ready", 32'(if1.instruction_ready), 32'd1);
        check("t5_rst_ci",    if1.current_instruction,    32'd0);
        tick();
        check("t5_rst_wr2",   32'(if1.register_write_n),  32'd1);
        reset_n = 1'b1;
        tick();
        if1.instruction_valid = 1'b1; if1.instruction = 32'h00308193;
        tick();
        if1.instruction_valid = 1'b0;
        check("t5_new_ci", if1.current_instruction, 32'h00308193);
        tick();
        tick();
        check("t5_new_wr", 32'(if1.register_write_n), 32'd0);
        check("t5_new_pc", 32'(if1.pc_advance),       32'd1);
        tick();

        // 6: EXEC_CYCLES=4, three back-to-back OP-IMM
        accepts = 0; pulses = 0; first_pc = -1; last_pc = -1;
        gap_bad = 0; overlap = 0; imm_low = 0;
        if4.instruction = 32'h00700293;
        if4.instruction_valid = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            if (if4.instruction_ready && if4.instruction_valid) accepts++;
            tick();
            if (accepts == 3) if4.instruction_valid = 1'b0;
            lows = int'(!if4.alu_imm_enable_n) + int'(!if4.alu_reg_enable_n)
                 + int'(!if4.branch_enable_n);
            if (lows > 1) overlap++;
            if (!if4.alu_imm_enable_n) imm_low++;
            if (if4.pc_advance) begin
                if (pulses == 0) first_pc = c;
                else if (c - last_pc != 7) gap_bad++;
                last_pc = c;
                pulses++;
            end
        end
        check("t6_pulses",   32'(pulses),   32'd3);
        check("t6_first_pc", 32'(first_pc), 32'd6);
        check("t6_last_pc",  32'(last_pc),  32'd20);
        check("t6_gap",      32'(gap_bad),  32'd0);
        check("t6_overlap",  32'(overlap),  32'd0);
        check("t6_imm_low",  32'(imm_low),  32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
